// File: rtl/sram_stream_reader_if.sv
// rtl/sram_stream_reader_if.sv - output word stream between the SRAM reader and the neuron datapath
interface sram_stream_reader_if #(
    parameter int WIDTH = 32
) ();
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_word;
    logic                    out_last;

    modport master (
        output out_valid,
        output out_word,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_word,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/sram_stream_reader.sv
// rtl/sram_stream_reader.sv - burst reader for a 1-cycle-latency SRAM with a 2-entry credit-managed output buffer
module sram_stream_reader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [AW-1:0]           base_addr,
    input  logic [AW:0]             count,
    output logic                    busy,
    output logic                    done,
    output logic [AW-1:0]           mem_addr,
    output logic                    mem_write_enable,
    output logic [WIDTH-1:0]        mem_write_word,
    input  logic signed [WIDTH-1:0] mem_word,
    sram_stream_reader_if.master    out_if
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [AW-1:0]           mem_addr_q, mem_addr_d;
    logic [AW:0]             remaining_q, remaining_d;
    logic                    inflight_q, inflight_d;
    logic                    inflight_last_q, inflight_last_d;
    logic signed [WIDTH-1:0] fifo_word_q [2];
    logic signed [WIDTH-1:0] fifo_word_d [2];
    logic                    fifo_last_q [2];
    logic                    fifo_last_d [2];
    logic                    rd_ptr_q, rd_ptr_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic [1:0]              occ_q, occ_d;
    logic                    done_q, done_d;

    logic       pop;
    logic       issue;
    logic [2:0] load;

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        mem_addr_d      = mem_addr_q;
        remaining_d     = remaining_q;
        fifo_word_d     = fifo_word_q;
        fifo_last_d     = fifo_last_q;
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        done_d          = 1'b0;

        pop   = (occ_q != 2'd0) && out_if.out_ready;
        load  = 3'(occ_q) + 3'(inflight_q);
        // A same-cycle pop frees a slot, so a full buffer can still accept one more read.
        issue = (state_q == S_READ) && (remaining_q != '0) && ((load < 3'd2) || pop);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        state_d     = S_READ;
                        addr_d      = base_addr;
                        remaining_d = count;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (issue && (remaining_q == (AW+1)'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && fifo_last_q[rd_ptr_q]) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            mem_addr_d  = addr_q;
            addr_d      = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
            remaining_d = remaining_q - (AW+1)'(1);
        end
        inflight_d      = issue;
        inflight_last_d = issue && (remaining_q == (AW+1)'(1));

        if (inflight_q) begin
            fifo_word_d[wr_ptr_q] = mem_word;
            fifo_last_d[wr_ptr_q] = inflight_last_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        occ_d = occ_q + 2'(inflight_q) - 2'(pop);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            mem_addr_q      <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_word_q[0]  <= '0;
            fifo_word_q[1]  <= '0;
            fifo_last_q[0]  <= 1'b0;
            fifo_last_q[1]  <= 1'b0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            occ_q           <= '0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            mem_addr_q      <= mem_addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            fifo_word_q     <= fifo_word_d;
            fifo_last_q     <= fifo_last_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            occ_q           <= occ_d;
            done_q          <= done_d;
        end
    end

    // The issuing address must reach the SRAM in the issue cycle itself, so it bypasses the hold register.
    assign mem_addr         = issue ? addr_q : mem_addr_q;
    assign mem_write_enable = 1'b0;
    assign mem_write_word   = '0;
    assign busy             = (state_q != S_IDLE);
    assign done             = done_q;

    assign out_if.out_valid = (occ_q != 2'd0);
    assign out_if.out_word  = fifo_word_q[rd_ptr_q];
    assign out_if.out_last  = (occ_q != 2'd0) && fifo_last_q[rd_ptr_q];
endmodule

// File: tb/tb_sram_stream_reader.sv
// tb/tb_sram_stream_reader.sv - directed table-driven bench for sram_stream_reader
module tb_sram_stream_reader;
    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic [7:0]         base_addr = '0;
    logic [8:0]         count = '0;
    logic               busy, done;
    logic [7:0]         mem_addr;
    logic               mem_write_enable;
    logic [31:0]        mem_write_word;
    logic signed [31:0] mem_word;
    logic signed [31:0] mem [256];

    int total = 0;
    int bad   = 0;

    sram_stream_reader_if #(.WIDTH(32)) sif ();

    sram_stream_reader #(.WIDTH(32), .DEPTH(256)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .base_addr        (base_addr),
        .count            (count),
        .busy             (busy),
        .done             (done),
        .mem_addr         (mem_addr),
        .mem_write_enable (mem_write_enable),
        .mem_write_word   (mem_write_word),
        .mem_word         (mem_word),
        .out_if           (sif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_word <= mem[mem_addr];

    typedef struct {
        int         base;
        int         cnt;
        logic [7:0] pat;
        int         poke;
        int         exp_first;
        int         exp_last;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_burst(input int base, input int cnt, input logic [7:0] pat, input int poke,
                             input int exp_first, input int exp_last);
        int idx = 0;
        int issued = 0;
        int k = 0;
        int last_pop_k = -1;
        int nxt;
        bit fin = 0;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic pl = 1'b0;
        logic signed [31:0] pw = '0;
        @(negedge clk);
        start     = 1'b1;
        base_addr = base[7:0];
        count     = cnt[8:0];
        sif.out_ready = 1'b0;
        nxt = base;
        while (!fin && k < 3000) begin
            @(negedge clk);
            k++;
            start = (k == poke);
            if (k == poke) begin
                base_addr = 8'd50;
                count     = 9'd3;
            end
            sif.out_ready = pat[k % 8];
            #1;
            if (last_pop_k >= 0) begin
                chk("done_pulse", done, 1);
                chk("busy_drop", busy, 0);
                chk("valid_after", sif.out_valid, 0);
                fin = 1;
            end else begin
                chk("busy_burst", busy, 1);
                chk("done_early", done, 0);
                if (k == 1) chk("first_addr", mem_addr, base);
                if (issued < cnt && mem_addr == nxt[7:0]) begin
                    issued++;
                    nxt = (nxt + 1) % 256;
                end
                if (pat == 8'hFF && k <= cnt) chk("addr_seq", mem_addr, (base + k - 1) % 256);
                if (pv && !pr) begin
                    chk("stall_valid", sif.out_valid, 1);
                    chk("stall_word", sif.out_word, pw);
                    chk("stall_last", sif.out_last, pl);
                end
                if (sif.out_valid && sif.out_ready) begin
                    chk("word", sif.out_word, ((base + idx) % 256) + 100);
                    chk("last_flag", sif.out_last, (idx == cnt - 1) ? 1 : 0);
                    if (pat == 8'hFF) chk("pop_cycle", k, idx + 3);
                    if (idx == 0) chk("first_word", sif.out_word, exp_first);
                    if (idx == cnt - 1) chk("last_word", sif.out_word, exp_last);
                    idx++;
                    if (idx == cnt) last_pop_k = k;
                end
                chk("reads_ahead", (issued - idx <= 2) ? 1 : 0, 1);
                pv = sif.out_valid;
                pr = sif.out_ready;
                pw = sif.out_word;
                pl = sif.out_last;
            end
        end
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL burst_timeout: got %0d words expected %0d", idx, cnt);
        end
        chk("word_count", idx, cnt);
        start = 1'b0;
        sif.out_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = i + 100;
        sif.out_ready = 1'b0;

        vecs[0] = '{4,   4,   8'hFF,       0, 104, 107};
        vecs[1] = '{4,   4,   8'b1001_0010, 0, 104, 107};
        vecs[2] = '{254, 4,   8'hFF,       0, 354, 101};
        vecs[3] = '{0,   256, 8'hFF,       0, 100, 355};
        vecs[4] = '{10,  5,   8'hFF,       2, 110, 114};
        vecs[5] = '{200, 3,   8'b0101_0101, 0, 300, 302};
        vecs[6] = '{255, 1,   8'hFF,       0, 355, 355};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", sif.out_valid, 0);
        chk("rst_last", sif.out_last, 0);
        chk("rst_word", sif.out_word, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_we", mem_write_enable, 0);
        chk("rst_wword", mem_write_word, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int v = 0; v < 7; v++) begin
            run_burst(vecs[v].base, vecs[v].cnt, vecs[v].pat, vecs[v].poke,
                      vecs[v].exp_first, vecs[v].exp_last);
        end

        // count == 0: no stream, busy never rises, done one cycle after start
        @(negedge clk);
        start = 1'b1;
        base_addr = 8'd7;
        count = 9'd0;
        sif.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_valid", sif.out_valid, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk("zero_idle_valid", sif.out_valid, 0);
            chk("zero_idle_busy", busy, 0);
            chk("zero_idle_done", done, 0);
        end

        // reset after two of eight words have been popped
        @(negedge clk);
        start = 1'b1;
        base_addr = 8'd20;
        count = 9'd8;
        sif.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("pre_rst_word0", sif.out_word, 120);
        @(negedge clk);
        #1;
        chk("pre_rst_word1", sif.out_word, 121);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_valid", sif.out_valid, 0);
        chk("mid_rst_last", sif.out_last, 0);
        chk("mid_rst_word", sif.out_word, 0);
        chk("mid_rst_addr", mem_addr, 0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            chk("post_rst_valid", sif.out_valid, 0);
        end
        sif.out_ready = 1'b0;
        run_burst(30, 6, 8'b1011_0110, 0, 130, 135);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_stream_reader.md
# sram_stream_reader

Read-side initiator for the synchronous single-port `sram` neuron-state/weight memory. Given a base address and a word count, it issues sequential reads to the SRAM, absorbs the memory's one-cycle registered read latency, and delivers the words on a valid/ready stream to the neuron datapath. A 2-entry output buffer with credit-based issue sustains one word per cycle under no backpressure and loses nothing under backpressure.

## Interface
- `WIDTH`, 32: bits per word; must match the attached `sram`.
- `DEPTH`, 256: words in the attached `sram`; `AW = $clog2(DEPTH)`.
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: synchronous, active-low. Sampled on the `clk` rising edge.
- `start` input 1: begin a burst; honoured only in IDLE.
- `base_addr` input AW: first address, sampled with `start`.
- `count` input AW+1: words to read (0..DEPTH), sampled with `start`.
- `busy` output 1: high from the cycle after `start` is accepted until the burst completes.
- `done` output 1: one-cycle pulse at burst completion.
- `mem_addr` output AW: to `sram.addr`.
- `mem_write_enable` output 1: to `sram.write_enable`; constant 0.
- `mem_write_word` output WIDTH: to `sram.write_word`; constant 0.
- `mem_word` input WIDTH signed: from `sram.word`; valid the cycle after the read issue.
- `out_valid` output 1: stream word available.
- `out_ready` input 1: consumer accepts the word.
- `out_word` output WIDTH signed: stream data.
- `out_last` output 1: qualifies the final word of the burst.

## Operation
- FSM states: IDLE, READ, DRAIN.
- IDLE -> READ when `start` is high and `count` != 0. Latch `addr_q = base_addr`, `remaining = count`, `delivered = count`.
- IDLE with `start` high and `count` == 0: no reads, no stream output. `done` pulses the next cycle. `busy` stays 0.
- Issue condition in READ is `remaining != 0 && (occ + inflight < 2 || pop)`, where `pop = out_valid && out_ready`.
  - On issue: `mem_addr = addr_q`, `addr_q` increments modulo DEPTH (DEPTH-1 wraps to 0), `remaining` decrements, and `inflight` is set for the next cycle.
- Cycle after an issue: `mem_word` is pushed into the 2-entry FIFO, tagged last if it is the burst's final read.
- READ -> DRAIN when the final read issues. DRAIN -> IDLE on the pop of the word tagged last.
- `out_word`, `out_valid` and `out_last` come from the FIFO head. The FIFO never overflows; occupancy + inflight ≤ 2 always holds.
- `mem_addr` holds its last value when not issuing. Reads are side-effect free, so the SRAM may be clocked regardless.
- `start` while `busy`: ignored, no effect on the current burst.
- Reset (`reset` == 0): FSM to IDLE, FIFO and `inflight` cleared, counters and `addr_q` to 0. A burst in progress is abandoned and its in-flight SRAM data is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_last`=0, `out_word`=0, `mem_addr`=0, `mem_write_enable`=0, `mem_write_word`=0.
- `start` accepted at the edge ending cycle T. `busy`=1 and the first issue (`mem_addr`=base) occur in T+1. `mem_word` is valid in T+2. First `out_valid` is in T+3.
- With `out_ready` held high, N words appear on N consecutive cycles T+3..T+N+2.
- `out_last` is high with word N only.
- `done` pulses in the cycle after the last pop; `busy` drops in that same cycle. A new `start` is accepted in that cycle.
- Backpressure: `out_word`, `out_valid` and `out_last` are held stable while `out_valid && !out_ready`.
- Issue stalls exactly while occupancy + inflight = 2 with no pop.

## Test plan
- Preload mem[i]=i+100. `start` with base=4, count=4, `out_ready`=1 -> `out_word` 104,105,106,107 on T+3..T+6. `out_last` only on 107. `done` pulses at T+7.
- Same burst with `out_ready` toggling 1,0,0,1,... -> same 4 words in order, no drop or duplicate, data stable while stalled, never more than 2 reads ahead of pops.
- base=254, count=4, DEPTH=256 -> `mem_addr` sequence 254,255,0,1 and words mem[254],mem[255],mem[0],mem[1].
- count=0 -> `out_valid` never asserts, `busy` stays 0, `done` pulses the cycle after `start`. count=256 with base=0 -> 256 words, last is mem[255].
- Assert `start` again mid-burst with a different base -> ignored, original burst completes unchanged.
- Drive `reset`=0 for one cycle after 2 of 8 words are popped -> all outputs return to reset values next cycle, no further `out_valid`. A fresh `start` then runs a correct burst.
